fifo_rd_ptr_empty: RTL and testbench

- Read-domain pointer and empty-flag generator for the asynchronous FIFO.
- Consumes the write pointer (Gray) after it has passed through the 2-FF synchronizer clocked by rd_clk.
- Produces the read address for the dual-port RAM and the Gray read pointer that the write-domain synchronizer captures.
- Maintains a registered, pessimistic empty flag and an underflow indication.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_ptr_empty_if.sv | 42 ++++
 rtl/fifo_rd_ptr_empty_gray_to_bin.sv | 14 +
 rtl/fifo_rd_ptr_empty.sv | 88 ++++++++
 tb/tb_fifo_rd_ptr_empty.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks.
// Holds the default RAM address width and the Gray/binary helpers that both
// the read-side (fifo_rd_ptr_empty) and write-side pointer blocks use.
// The helpers work on 32-bit values. A narrower pointer is zero-extended on
// the way in and truncated on the way out. The upper zeros do not disturb
// either conversion, so one function serves every pointer width up to 32.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ptr_empty_if.sv
// Read-side bundle between the FIFO read pointer block and its consumer.
//   rd_en           consumer -> block  read request
//   rq2_wptr        sync     -> block  Gray write pointer, already in rd_clk domain
//   rd_addr         block -> consumer  RAM read address
//   rd_ptr_gray     block -> sync      registered Gray read pointer
//   rd_empty        block -> consumer  registered empty flag
//   rd_underflow    block -> consumer  read-while-empty pulse
//   rd_fill         block -> consumer  fill level         (RD_FILL_LEVEL_EN only)
//   rd_almost_empty block -> consumer  almost-empty flag  (RD_FILL_LEVEL_EN only)
// Modport slave is the pointer block; modport master is the consumer side.
interface fifo_rd_ptr_empty_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  rd_empty;
  logic                  rd_underflow;
`ifdef RD_FILL_LEVEL_EN
  logic [ADDR_WIDTH:0]   rd_fill;
  logic                  rd_almost_empty;
`endif

  modport slave (
    input  rd_en, rq2_wptr,
`ifdef RD_FILL_LEVEL_EN
    output rd_fill, rd_almost_empty,
`endif
    output rd_addr, rd_ptr_gray, rd_empty, rd_underflow
  );

  modport master (
    output rd_en, rq2_wptr,
`ifdef RD_FILL_LEVEL_EN
    input  rd_fill, rd_almost_empty,
`endif
    input  rd_addr, rd_ptr_gray, rd_empty, rd_underflow
  );
endinterface

// File: rtl/fifo_rd_ptr_empty_gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
//   gray  input  WIDTH  Gray-coded value
//   bin   output WIDTH  binary value
module gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and empty-flag generator for the asynchronous FIFO.
// The block keeps the binary read pointer and the registered Gray copy of it
// for the write-domain synchronizer. It also produces a pessimistic registered
// empty flag and a registered underflow pulse.
//   rd_clk   input  read-domain clock
//   rd_rstn  input  asynchronous active-low reset
//   rd_if    fifo_rd_ptr_empty_if.slave (rd_en, rq2_wptr in; rd_addr,
//            rd_ptr_gray, rd_empty, rd_underflow out)
// Optional macro RD_FILL_LEVEL_EN adds the rd_fill and rd_almost_empty outputs.
// It also adds the AE_THRESH parameter.
module fifo_rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
`ifdef RD_FILL_LEVEL_EN
  ,
  parameter int AE_THRESH  = 2
`endif
) (
  input logic               rd_clk,
  input logic               rd_rstn,
  fifo_rd_ptr_empty_if.slave rd_if
);
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] rgray_q;
  logic             empty_q;
  logic             underflow_q;
  logic             pop;

  assign pop        = rd_if.rd_en & ~empty_q;
  assign rbin_next  = rbin + PTR_W'(pop);
  assign rgray_next = PTR_W'(bin2gray(32'(rbin_next)));

  // Empty compares the full pointer width, including the wrap bit. This keeps
  // a full FIFO (same address, opposite wrap bit) from reading as empty.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rbin        <= '0;
      rgray_q     <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rgray_q     <= rgray_next;
      empty_q     <= (rgray_next == rd_if.rq2_wptr);
      underflow_q <= rd_if.rd_en & empty_q;
    end
  end

  assign rd_if.rd_addr      = rbin[ADDR_WIDTH-1:0];
  assign rd_if.rd_ptr_gray  = rgray_q;
  assign rd_if.rd_empty     = empty_q;
  assign rd_if.rd_underflow = underflow_q;

`ifdef RD_FILL_LEVEL_EN
  localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] fill_next;
  logic [PTR_W-1:0] fill_q;
  logic             almost_empty_q;

  gray_to_bin #(.WIDTH(PTR_W)) u_wptr_g2b (
    .gray (rd_if.rq2_wptr),
    .bin  (wbin_s)
  );

  // Modulo subtraction absorbs the pointer wrap. The result lies in 0..DEPTH.
  assign fill_next = wbin_s - rbin_next;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      fill_q         <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      fill_q         <= fill_next;
      almost_empty_q <= (fill_next <= AE_LIMIT);
    end
  end

  assign rd_if.rd_fill         = fill_q;
  assign rd_if.rd_almost_empty = almost_empty_q;
`endif
endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
module tb_fifo_rd_ptr_empty;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic rd_clk;
  logic rd_rstn;

  fifo_rd_ptr_empty_if #(.ADDR_WIDTH(AW)) rif ();

  fifo_rd_ptr_empty #(.ADDR_WIDTH(AW)) dut (
    .rd_clk  (rd_clk),
    .rd_rstn (rd_rstn),
    .rd_if   (rif.slave)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int check_cnt = 0;
  int err_cnt   = 0;

  // Reference model: entries are counted as integers. The write side is an
  // integer count w. Pops so far are counted in rcnt. Both counts are modulo 2*DEPTH.
  int   w_cnt;
  int   rcnt;
  logic m_empty;
  logic m_under;
  logic [AW:0] last_gray;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all(input int pops_now);
    int fill;
    check_val("rd_addr", 32'(rif.rd_addr), 32'(rcnt % DEPTH));
    check_val("rd_ptr_gray", 32'(rif.rd_ptr_gray), 32'(to_gray(rcnt)));
    check_val("rd_empty", 32'(rif.rd_empty), 32'(m_empty));
    check_val("rd_underflow", 32'(rif.rd_underflow), 32'(m_under));
    check_val("gray_toggle", 32'($countones(rif.rd_ptr_gray ^ last_gray)), 32'(pops_now));
    last_gray = rif.rd_ptr_gray;
    fill = (w_cnt - rcnt + PMOD) % PMOD;
`ifdef RD_FILL_LEVEL_EN
    check_val("rd_fill", 32'(rif.rd_fill), 32'(fill));
    check_val("rd_almost_empty", 32'(rif.rd_almost_empty), 32'(fill <= 2));
`endif
    if (fill > DEPTH) check_val("model_fill_range", 32'(fill), 32'(DEPTH));
  endtask

  // One clock: apply inputs, advance the model, then compare 1 ns after the edge.
  task automatic step(input logic en, input int wv);
    int   pops_now;
    logic was_empty;
    w_cnt = wv % PMOD;
    rif.rd_en    = en;
    rif.rq2_wptr = to_gray(w_cnt);
    @(posedge rd_clk);
    #1;
    was_empty = m_empty;
    pops_now  = (en && !was_empty) ? 1 : 0;
    rcnt      = (rcnt + pops_now) % PMOD;
    m_empty   = (rcnt == w_cnt);
    m_under   = en && was_empty;
    check_all(pops_now);
  endtask

  task automatic do_reset();
    #3;
    rif.rd_en = 1'b1;
    rd_rstn   = 1'b0;
    #1;
    rcnt = 0; w_cnt = 0; m_empty = 1'b1; m_under = 1'b0; last_gray = '0;
    check_val("rst_empty", 32'(rif.rd_empty), 32'd1);
    check_val("rst_addr", 32'(rif.rd_addr), 32'd0);
    check_val("rst_gray", 32'(rif.rd_ptr_gray), 32'd0);
    check_val("rst_under", 32'(rif.rd_underflow), 32'd0);
`ifdef RD_FILL_LEVEL_EN
    check_val("rst_fill", 32'(rif.rd_fill), 32'd0);
    check_val("rst_ae", 32'(rif.rd_almost_empty), 32'd1);
`endif
    rif.rq2_wptr = '0;
    repeat (2) begin
      @(posedge rd_clk);
      #1;
      check_val("rst_hold_empty", 32'(rif.rd_empty), 32'd1);
      check_val("rst_hold_gray", 32'(rif.rd_ptr_gray), 32'd0);
      check_val("rst_hold_under", 32'(rif.rd_underflow), 32'd0);
    end
    rif.rd_en = 1'b0;
    #2;
    rd_rstn = 1'b1;
  endtask

  initial begin
    int pops_done;
    int w_adv;
    rd_rstn      = 1'b0;
    rif.rd_en    = 1'b0;
    rif.rq2_wptr = '0;
    rcnt = 0; w_cnt = 0; m_empty = 1'b1; m_under = 1'b0; last_gray = '0;
    #2;
    do_reset();

    // Single entry
    step(1'b0, 1);
    check_val("single_not_empty", 32'(rif.rd_empty), 32'd0);
    step(1'b1, 1);
    check_val("single_addr", 32'(rif.rd_addr), 32'd1);
    check_val("single_gray", 32'(rif.rd_ptr_gray), 32'b00001);
    check_val("single_empty", 32'(rif.rd_empty), 32'd1);

    // Underflow for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1);
      check_val("uf_pulse", 32'(rif.rd_underflow), 32'd1);
      check_val("uf_addr_hold", 32'(rif.rd_addr), 32'd1);
    end
    step(1'b0, 1);
    check_val("uf_clear", 32'(rif.rd_underflow), 32'd0);

    // Wrap: 32 pops from a fresh reset with continuous rd_en
    do_reset();
    pops_done = 0;
    w_adv     = 0;
    for (int i = 0; i < 200 && pops_done < PMOD; i++) begin
      int rbefore;
      rbefore = rcnt;
      if (w_adv < PMOD && ((w_cnt - rcnt + PMOD) % PMOD) < DEPTH) w_adv++;
      step(1'b1, w_adv);
      if (rcnt != rbefore) pops_done++;
    end
    check_val("wrap_pops", 32'(pops_done), 32'(PMOD));
    check_val("wrap_gray_zero", 32'(rif.rd_ptr_gray), 32'd0);
    check_val("wrap_empty", 32'(rif.rd_empty), 32'd1);

    // Full must not look empty
    do_reset();
    step(1'b0, DEPTH);
    check_val("full_not_empty", 32'(rif.rd_empty), 32'd0);
    pops_done = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DEPTH);
      if (i < DEPTH - 1) check_val("full_drain_nonempty", 32'(rif.rd_empty), 32'd0);
    end
    check_val("full_drained_empty", 32'(rif.rd_empty), 32'd1);
    check_val("full_drained_addr", 32'(rif.rd_addr), 32'd0);

`ifdef RD_FILL_LEVEL_EN
    do_reset();
    step(1'b0, 5);
    check_val("fill5", 32'(rif.rd_fill), 32'd5);
    check_val("ae5", 32'(rif.rd_almost_empty), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 5);
    check_val("fill2", 32'(rif.rd_fill), 32'd2);
    check_val("ae2", 32'(rif.rd_almost_empty), 32'd1);
`endif

    // Randomized traffic, then a mid-run reset and more traffic
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 600; i++) begin
        int  nw;
        logic en;
        nw = w_cnt;
        if (((w_cnt - rcnt + PMOD) % PMOD) < DEPTH && $urandom_range(0, 2) != 0)
          nw = w_cnt + int'($urandom_range(1, 1));
        en = ($urandom_range(0, 3) != 0);
        step(en, nw);
      end
      if (phase == 0) begin
        step(1'b0, (rcnt + 3) % PMOD);
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
